// File: rtl/toaplan2_cen_bank.sv
// Bank of fractional clock-enable generators: each channel emits CEN at CLK*n/m
// and CENB near the half phase, and can optionally be cascaded off its predecessor.
module toaplan2_cen_bank #(
    parameter int CH = 4,
    parameter int WC = 16,
    localparam int SW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          CLK,
    input  logic          RESET_n,
    input  logic          CFG_WE,
    input  logic [SW-1:0] CFG_SEL,
    input  logic [WC-1:0] CFG_N,
    input  logic [WC-1:0] CFG_M,
    input  logic          CFG_CASC,
    input  logic          PAUSE,
    input  logic          SYNC,
    output logic [CH-1:0] CEN,
    output logic [CH-1:0] CENB,
    output logic [CH-1:0] EN_STAT
);

    logic [WC-1:0] n_q   [CH];
    logic [WC-1:0] n_d   [CH];
    logic [WC-1:0] m_q   [CH];
    logic [WC-1:0] m_d   [CH];
    logic [WC-1:0] acc_q [CH];
    logic [WC-1:0] acc_d [CH];
    logic [CH-1:0] casc_q, casc_d;
    logic [CH-1:0] cen_q, cen_d;
    logic [CH-1:0] cenb_q, cenb_d;
    logic [CH-1:0] valid, wr_hit, adv;
    logic [CH:0]   pred;

    // pred[i] is the registered CEN of channel i-1; channel 0 has no predecessor
    assign pred = {cen_q, 1'b0};

    always_comb begin
        valid  = '0;
        wr_hit = '0;
        adv    = '0;
        for (int i = 0; i < CH; i++) begin
            valid[i]  = (n_q[i] != '0) && (m_q[i] != '0) && (n_q[i] <= m_q[i]);
            wr_hit[i] = CFG_WE && (32'(CFG_SEL) == 32'(i));
            adv[i]    = valid[i] && !PAUSE && !SYNC && !wr_hit[i] &&
                        (!casc_q[i] || (i == 0) || pred[i]);
        end
    end

    logic [WC:0]   s;
    logic [WC-1:0] half;

    always_comb begin
        n_d    = n_q;
        m_d    = m_q;
        acc_d  = acc_q;
        casc_d = casc_q;
        cen_d  = '0;
        cenb_d = '0;
        s      = '0;
        half   = '0;
        for (int i = 0; i < CH; i++) begin
            if (wr_hit[i]) begin
                n_d[i]    = CFG_N;
                m_d[i]    = CFG_M;
                casc_d[i] = CFG_CASC;
                acc_d[i]  = '0;
            end else if (SYNC) begin
                acc_d[i] = '0;
            end else if (adv[i]) begin
                s    = {1'b0, acc_q[i]} + {1'b0, n_q[i]};
                half = m_q[i] >> 1;
                if (s >= {1'b0, m_q[i]}) begin
                    // n <= m keeps s - m below m, so the truncation is lossless
                    acc_d[i] = WC'(s - {1'b0, m_q[i]});
                    cen_d[i] = 1'b1;
                end else begin
                    acc_d[i] = s[WC-1:0];
                    if ((acc_q[i] < half) && (s >= {1'b0, half}))
                        cenb_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            for (int i = 0; i < CH; i++) begin
                n_q[i]   <= '0;
                m_q[i]   <= '0;
                acc_q[i] <= '0;
            end
            casc_q <= '0;
            cen_q  <= '0;
            cenb_q <= '0;
        end else begin
            n_q    <= n_d;
            m_q    <= m_d;
            acc_q  <= acc_d;
            casc_q <= casc_d;
            cen_q  <= cen_d;
            cenb_q <= cenb_d;
        end
    end

    assign CEN     = cen_q;
    assign CENB    = cenb_q;
    assign EN_STAT = valid;

endmodule

// File: doc/toaplan2_cen_bank.md
TOAPLAN2_CEN_BANK -- requirements
Module: toaplan2_cen_bank

Interface
REQ-001 The block SHALL expose these parameters, one per line: name, default, meaning.
- CH, 4, number of clock-enable channels (1..8)
- WC, 16, numerator/denominator/accumulator width in bits
REQ-002 The block SHALL expose these ports, one per line: name, direction, width, meaning.
- CLK  in  1  single system clock (96 MHz domain)
- RESET_n  in  1  asynchronous active-low reset
- CFG_WE  in  1  configuration write strobe, one cycle
- CFG_SEL  in  $clog2(CH) (min 1)  channel addressed by the write
- CFG_N  in  WC  numerator n
- CFG_M  in  WC  denominator m
- CFG_CASC  in  1  cascade mode: channel counts only on predecessor's CEN
- PAUSE  in  1  freeze all channels
- SYNC  in  1  realign all channels (clear accumulators)
- CEN  out  CH  per-channel enable pulse, rate CLK*n/m
- CENB  out  CH  per-channel half-phase enable pulse
- EN_STAT  out  CH  channel configured validly (0<n<=m)

Function
REQ-003 Each channel SHALL hold registers n, m, casc and an accumulator acc of WC bits; the sum s = acc + n SHALL be computed in WC+1 bits.
REQ-004 A channel SHALL be valid when n != 0, m != 0 and n <= m; an invalid channel SHALL keep acc = 0 and drive CEN = CENB = 0; EN_STAT reflects validity combinationally from the stored registers.
REQ-005 A channel advances on a cycle when valid, PAUSE = 0, SYNC = 0, no write to it that cycle, and (casc = 0, or channel index 0, or CEN[i-1] = 1 that cycle).
REQ-006 On an advance with s >= m: acc <= s - m, CEN[i] <= 1, CENB[i] <= 0.
REQ-007 On an advance with s < m, acc < (m>>1) and s >= (m>>1): acc <= s, CENB[i] <= 1, CEN[i] <= 0.
REQ-008 On any other advance: acc <= s, CEN[i] <= 0, CENB[i] <= 0.
REQ-009 On a non-advance cycle, acc SHALL hold (except REQ-010/011) and CEN[i], CENB[i] SHALL be registered 0.
REQ-010 CEN and CENB SHALL be registered outputs; each SHALL be high for exactly one CLK cycle per event and never simultaneously on one channel.
REQ-011 CFG_WE = 1 SHALL load n, m, casc into channel CFG_SEL and clear its acc on the same edge; CFG_SEL >= CH SHALL be ignored; other channels are unaffected.
REQ-012 SYNC = 1 SHALL clear every accumulator and force all CEN/CENB to 0 on that edge; CFG_WE in the same cycle SHALL still load its configuration.
REQ-013 PAUSE = 1 SHALL hold every accumulator and force all CEN/CENB to 0; configuration writes during PAUSE SHALL still apply (acc cleared, channel stays paused).
REQ-014 SYNC takes priority over PAUSE for the accumulator (cleared).
REQ-015 n = m SHALL yield CEN high every advance cycle and CENB never.
REQ-016 In cascade mode, channel i's effective rate SHALL be rate(i-1)*n/m, with one extra CLK of latency per stage from the registered predecessor CEN.
REQ-017 Accumulators SHALL never exceed m-1 after any valid advance (no wrap beyond WC bits).

Reset
REQ-018 While RESET_n = 0, asynchronously: all n, m, casc, acc SHALL be 0; CEN, CENB SHALL be 0; EN_STAT SHALL be 0.
REQ-019 After RESET_n rises, channels SHALL remain idle until configured; reset asserted mid-operation SHALL abort pulses immediately.

Verification
REQ-020 Write ch0 n=1 m=4 after reset -> CEN[0] high after edges 4, 8, 12 following the write edge; CENB[0] after edges 2, 6, 10.
REQ-021 ch1 n=9 m=128 for 1280 cycles -> exactly 90 CEN[1] pulses, spacing 14 or 15 cycles, never two consecutive cycles.
REQ-022 ch0 n=1 m=7; ch1 casc=1 n=1 m=2 -> CEN[1] once per two CEN[0] pulses, one cycle after every second CEN[0].
REQ-023 Running ch0 (n=1 m=4), assert PAUSE 3 cycles then SYNC 1 cycle -> no pulses during pause; next CEN[0] 4 edges after SYNC edge.
REQ-024 Write n=5 m=3, then n=0 m=8 -> EN_STAT[ch]=0, CEN/CENB stay 0; write n=3 m=3 -> CEN high every cycle, CENB never.
REQ-025 Assert RESET_n=0 mid-pulse -> CEN/CENB drop to 0 without a clock edge; EN_STAT all 0 after release.
